// File: rtl/multicycle_controller_if.sv
// Memory bus between the multicycle controller (master) and its memory (slave).
interface multicycle_controller_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle instruction-sequencing controller: fetch, decode, data access and
// trap entry over a single shared memory bus with a wait-state timeout.
module multicycle_controller #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 16,
   parameter int unsigned CNT_W    = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   multicycle_controller_if.master mem,
   output logic [31:0]             pc,
   output logic [31:0]             ir,
   output logic                    dec_valid,
   input  logic                    dp_illegal,
   input  logic                    dp_ecall,
   input  logic                    dp_mret,
   input  logic                    dp_load,
   input  logic                    dp_store,
   input  logic                    dp_unsigned,
   input  logic [1:0]              dp_size,
   input  logic [31:0]             dp_addr,
   input  logic [31:0]             dp_wdata,
   input  logic [31:0]             dp_pc_next,
   input  logic [31:0]             csr_mtvec,
   input  logic [31:0]             csr_mepc,
   output logic                    rd_we,
   output logic [31:0]             rd_wd,
   output logic                    trap_we,
   output logic [31:0]             trap_cause,
   output logic [31:0]             trap_epc,
   output logic                    retire,
   output logic [CNT_W-1:0]        instret
);

   typedef enum logic [1:0] {FETCH, DECODE, MEM, TRAP} state_t;

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      ir_q, ir_d;
   logic [7:0]       wait_q, wait_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic             mem_req_q, mem_req_d;
   logic             mem_we_q, mem_we_d;
   logic [31:0]      mem_addr_q, mem_addr_d;
   logic [3:0]       mem_be_q, mem_be_d;
   logic [31:0]      mem_wdata_q, mem_wdata_d;
   logic             dec_valid_q, dec_valid_d;
   logic             rd_we_q, rd_we_d;
   logic [31:0]      rd_wd_q, rd_wd_d;
   logic             trap_we_q, trap_we_d;
   logic [31:0]      trap_cause_q, trap_cause_d;
   logic [31:0]      trap_epc_q, trap_epc_d;
   logic             retire_q, retire_d;

   logic [1:0]       ofs;
   logic             misaligned;
   logic [3:0]       be_sel;
   logic [31:0]      wdata_sh;
   logic [15:0]      lane;
   logic [31:0]      load_ext;

   logic             launch;
   logic [31:0]      launch_pc;
   logic             do_retire;
   logic             trap_go;
   logic [31:0]      trap_code;

   // Byte-lane steering and load extension derived from the effective address
   always_comb begin
      ofs        = dp_addr[1:0];
      misaligned = ((dp_size == 2'd1) && ofs[0]) || (dp_size[1] && (ofs != 2'd0));
      case (dp_size)
         2'd0:    be_sel = 4'b0001 << ofs;
         2'd1:    be_sel = 4'b0011 << ofs;
         default: be_sel = 4'b1111;
      endcase
      wdata_sh = dp_wdata << {ofs, 3'b000};
      lane     = 16'(mem.mem_rdata >> {ofs, 3'b000});
      case (dp_size)
         2'd0:    load_ext = dp_unsigned ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
         2'd1:    load_ext = dp_unsigned ? {16'h0, lane} : {{16{lane[15]}}, lane};
         default: load_ext = mem.mem_rdata;
      endcase
   end

   // Next-state and next-output computation for the sequencing FSM
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ir_d         = ir_q;
      wait_d       = wait_q;
      instret_d    = instret_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_be_d     = mem_be_q;
      mem_wdata_d  = mem_wdata_q;
      rd_wd_d      = rd_wd_q;
      trap_cause_d = trap_cause_q;
      trap_epc_d   = trap_epc_q;
      dec_valid_d  = 1'b0;
      rd_we_d      = 1'b0;
      trap_we_d    = 1'b0;
      retire_d     = 1'b0;
      launch       = 1'b0;
      launch_pc    = pc_q;
      do_retire    = 1'b0;
      trap_go      = 1'b0;
      trap_code    = '0;

      case (state_q)
         FETCH: begin
            if (!mem_req_q) begin
               // Only reached straight out of reset; later fetches are launched directly
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = pc_q;
               mem_be_d    = '1;
               mem_wdata_d = '0;
               wait_d      = '0;
            end else if (mem.mem_ready) begin
               mem_req_d   = 1'b0;
               ir_d        = mem.mem_rdata;
               wait_d      = '0;
               dec_valid_d = 1'b1;
               state_d     = DECODE;
            end else if (wait_q == WAIT_LAST) begin
               trap_go   = 1'b1;
               trap_code = 32'd1;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end

         DECODE: begin
            if (dp_illegal) begin
               trap_go   = 1'b1;
               trap_code = 32'd2;
            end else if (dp_ecall) begin
               trap_go   = 1'b1;
               trap_code = 32'd11;
            end else if ((dp_load || dp_store) && misaligned) begin
               trap_go   = 1'b1;
               trap_code = dp_load ? 32'd4 : 32'd6;
            end else if (dp_mret) begin
               do_retire = 1'b1;
               launch    = 1'b1;
               launch_pc = csr_mepc;
            end else if (dp_load || dp_store) begin
               mem_req_d   = 1'b1;
               mem_we_d    = !dp_load;
               mem_addr_d  = {dp_addr[31:2], 2'b00};
               mem_be_d    = be_sel;
               mem_wdata_d = wdata_sh;
               wait_d      = '0;
               state_d     = MEM;
            end else begin
               do_retire = 1'b1;
               launch    = 1'b1;
               launch_pc = dp_pc_next;
            end
         end

         MEM: begin
            if (mem.mem_ready) begin
               if (dp_load) begin
                  rd_we_d = 1'b1;
                  rd_wd_d = load_ext;
               end
               do_retire = 1'b1;
               launch    = 1'b1;
               launch_pc = dp_pc_next;
            end else if (wait_q == WAIT_LAST) begin
               trap_go   = 1'b1;
               trap_code = dp_load ? 32'd5 : 32'd7;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end

         TRAP: begin
            launch    = 1'b1;
            launch_pc = csr_mtvec;
         end

         default: state_d = FETCH;
      endcase

      if (do_retire) begin
         retire_d  = 1'b1;
         instret_d = instret_q + CNT_W'(1);
      end

      // The next fetch request is issued on the same edge that leaves the
      // previous instruction, so no idle bus cycle separates instructions
      if (launch) begin
         pc_d        = launch_pc;
         mem_req_d   = 1'b1;
         mem_we_d    = 1'b0;
         mem_addr_d  = launch_pc;
         mem_be_d    = '1;
         mem_wdata_d = '0;
         wait_d      = '0;
         state_d     = FETCH;
      end

      if (trap_go) begin
         mem_req_d    = 1'b0;
         mem_we_d     = 1'b0;
         wait_d       = '0;
         trap_we_d    = 1'b1;
         trap_cause_d = trap_code;
         trap_epc_d   = pc_q;
         state_d      = TRAP;
      end
   end

   // State and registered outputs; reset forces an idle fetch at RESET_PC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= FETCH;
         pc_q         <= RESET_PC;
         ir_q         <= '0;
         wait_q       <= '0;
         instret_q    <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_be_q     <= '0;
         mem_wdata_q  <= '0;
         dec_valid_q  <= 1'b0;
         rd_we_q      <= 1'b0;
         rd_wd_q      <= '0;
         trap_we_q    <= 1'b0;
         trap_cause_q <= '0;
         trap_epc_q   <= '0;
         retire_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ir_q         <= ir_d;
         wait_q       <= wait_d;
         instret_q    <= instret_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_be_q     <= mem_be_d;
         mem_wdata_q  <= mem_wdata_d;
         dec_valid_q  <= dec_valid_d;
         rd_we_q      <= rd_we_d;
         rd_wd_q      <= rd_wd_d;
         trap_we_q    <= trap_we_d;
         trap_cause_q <= trap_cause_d;
         trap_epc_q   <= trap_epc_d;
         retire_q     <= retire_d;
      end
   end

   assign mem.mem_req   = mem_req_q;
   assign mem.mem_we    = mem_we_q;
   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_be    = mem_be_q;
   assign mem.mem_wdata = mem_wdata_q;
   assign pc            = pc_q;
   assign ir            = ir_q;
   assign dec_valid     = dec_valid_q;
   assign rd_we         = rd_we_q;
   assign rd_wd         = rd_wd_q;
   assign trap_we       = trap_we_q;
   assign trap_cause    = trap_cause_q;
   assign trap_epc      = trap_epc_q;
   assign retire        = retire_q;
   assign instret       = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed scenarios plus a randomized
// instruction stream checked against an architectural reference model.
module tb_multicycle_controller;
   localparam logic [31:0] RST_PC = 32'h0000_0080;
   localparam int unsigned TMO    = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   multicycle_controller_if bus ();

   logic [31:0] pc, ir, rd_wd, trap_cause, trap_epc;
   logic        dec_valid, rd_we, trap_we, retire;
   logic [63:0] instret;
   logic        dp_illegal, dp_ecall, dp_mret, dp_load, dp_store, dp_unsigned;
   logic [1:0]  dp_size;
   logic [31:0] dp_addr, dp_wdata, dp_pc_next, csr_mtvec, csr_mepc;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference architectural state
   logic [31:0] m_pc;
   logic [63:0] m_instret;

   multicycle_controller #(.RESET_PC(RST_PC), .TIMEOUT(TMO), .CNT_W(64)) dut (
      .clk(clk), .rst_n(rst_n), .mem(bus),
      .pc(pc), .ir(ir), .dec_valid(dec_valid),
      .dp_illegal(dp_illegal), .dp_ecall(dp_ecall), .dp_mret(dp_mret),
      .dp_load(dp_load), .dp_store(dp_store), .dp_unsigned(dp_unsigned),
      .dp_size(dp_size), .dp_addr(dp_addr), .dp_wdata(dp_wdata),
      .dp_pc_next(dp_pc_next), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
      .rd_we(rd_we), .rd_wd(rd_wd), .trap_we(trap_we), .trap_cause(trap_cause),
      .trap_epc(trap_epc), .retire(retire), .instret(instret)
   );

   always #5 clk = ~clk;

   // Trap cause taken at decode (0 = no trap)
   function automatic int unsigned ref_cause(input bit ill, input bit ec, input bit ld, input bit st,
                                             input int unsigned size, input logic [31:0] addr);
      int unsigned a = addr % 4;
      if (ill) return 2;
      if (ec) return 11;
      if ((ld || st) && ((size == 1 && a % 2 == 1) || (size == 2 && a != 0))) return ld ? 4 : 6;
      return 0;
   endfunction

   // One enable bit per byte touched by the access
   function automatic logic [3:0] ref_be(input int unsigned size, input logic [31:0] addr);
      logic [3:0] be = '0;
      for (int unsigned k = 0; k < (1 << size); k++) be[(addr % 4) + k] = 1'b1;
      return be;
   endfunction

   // Loaded value: pick the addressed bytes, then extend arithmetically
   function automatic logic [31:0] ref_load(input logic [31:0] rdata, input int unsigned size,
                                            input logic [31:0] addr, input bit uns);
      longint unsigned span, v;
      if (size == 2) return rdata;
      span = 64'd1 << (8 << size);
      v = ({32'h0, rdata} >> (8 * (addr % 4))) % span;
      if (!uns && v >= span / 2) v = v + (64'h1_0000_0000 - span);
      return v[31:0];
   endfunction

   task automatic clear_dp();
      dp_illegal = 0; dp_ecall = 0; dp_mret = 0; dp_load = 0; dp_store = 0; dp_unsigned = 0;
      dp_size = 0; dp_addr = 0; dp_wdata = 0; dp_pc_next = 0;
   endtask

   // Memory side of an instruction fetch: optional wait states, then data
   task automatic fetch(input int unsigned waits, input logic [31:0] word,
                        output bit seen, output logic [31:0] addr);
      for (int i = 0; i < 8 && bus.mem_req !== 1'b1; i++) @(negedge clk);
      seen = (bus.mem_req === 1'b1);
      addr = bus.mem_addr;
      repeat (waits) @(negedge clk);
      bus.mem_ready = 1'b1;
      bus.mem_rdata = word;
      @(negedge clk);
      bus.mem_ready = 1'b0;
      bus.mem_rdata = $urandom;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b exp 0", bus.mem_req); end
      n_checks++; if (pc !== RST_PC) begin n_fail++; $display("FAIL rst_pc: got %h exp %h", pc, RST_PC); end
      n_checks++; if (ir !== 32'h0) begin n_fail++; $display("FAIL rst_ir: got %h exp 0", ir); end
      n_checks++; if (instret !== 64'h0) begin n_fail++; $display("FAIL rst_instret: got %0d exp 0", instret); end
      n_checks++; if ({dec_valid, retire, trap_we, rd_we, bus.mem_we} !== 5'b0) begin
         n_fail++; $display("FAIL rst_strobes: got %b exp 00000", {dec_valid, retire, trap_we, rd_we, bus.mem_we}); end
      n_checks++; if ({bus.mem_addr, bus.mem_be, bus.mem_wdata} !== 68'h0) begin
         n_fail++; $display("FAIL rst_bus: got %h/%h/%h exp 0", bus.mem_addr, bus.mem_be, bus.mem_wdata); end
      n_checks++; if ({rd_wd, trap_cause, trap_epc} !== 96'h0) begin
         n_fail++; $display("FAIL rst_regs: got %h/%h/%h exp 0", rd_wd, trap_cause, trap_epc); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_first_req: got %b exp 1", bus.mem_req); end
      n_checks++; if (bus.mem_addr !== RST_PC || bus.mem_be !== 4'hF || bus.mem_we !== 1'b0) begin
         n_fail++; $display("FAIL rst_first_fetch: got %h/%h/%b exp %h/f/0", bus.mem_addr, bus.mem_be, bus.mem_we, RST_PC); end
      m_pc = RST_PC;
      m_instret = 0;
   endtask

   task automatic test_alu_latency();
      bit seen; logic [31:0] fa;
      fetch(0, 32'h0000_0013, seen, fa);
      n_checks++; if (!seen || fa !== m_pc) begin n_fail++; $display("FAIL alu_fetch: got seen=%b addr %h exp 1/%h", seen, fa, m_pc); end
      n_checks++; if (dec_valid !== 1'b1 || retire !== 1'b0) begin
         n_fail++; $display("FAIL alu_cycle1: got dec_valid=%b retire=%b exp 1/0", dec_valid, retire); end
      dp_pc_next = 32'h4;
      @(negedge clk);
      m_pc = 32'h4; m_instret++;
      n_checks++; if (retire !== 1'b1 || dec_valid !== 1'b0) begin
         n_fail++; $display("FAIL alu_cycle2: got retire=%b dec_valid=%b exp 1/0", retire, dec_valid); end
      n_checks++; if (pc !== 32'h4) begin n_fail++; $display("FAIL alu_pc: got %h exp 4", pc); end
      n_checks++; if (instret !== 64'd1) begin n_fail++; $display("FAIL alu_instret: got %0d exp 1", instret); end
      clear_dp();
   endtask

   task automatic test_load_byte();
      bit seen; logic [31:0] fa;
      fetch(1, 32'h1030_0003, seen, fa);
      n_checks++; if (!seen || fa !== m_pc) begin n_fail++; $display("FAIL lb_fetch: got seen=%b addr %h exp 1/%h", seen, fa, m_pc); end
      dp_load = 1; dp_size = 0; dp_addr = 32'h103; dp_unsigned = 0; dp_pc_next = m_pc + 4;
      @(negedge clk);
      n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h100 || retire !== 1'b0) begin
         n_fail++; $display("FAIL lb_bus: got req=%b we=%b addr=%h retire=%b exp 1/0/100/0", bus.mem_req, bus.mem_we, bus.mem_addr, retire); end
      n_checks++; if (bus.mem_be !== 4'b1000) begin n_fail++; $display("FAIL lb_be: got %b exp 1000", bus.mem_be); end
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'h8000_0000 | ($urandom & 32'h00FF_FFFF);
      @(negedge clk);
      bus.mem_ready = 1'b0;
      m_pc = m_pc + 4; m_instret++;
      n_checks++; if (rd_we !== 1'b1 || rd_wd !== 32'hFFFF_FF80) begin
         n_fail++; $display("FAIL lb_data: got we=%b wd=%h exp 1/ffffff80", rd_we, rd_wd); end
      n_checks++; if (retire !== 1'b1 || pc !== m_pc || instret !== m_instret) begin
         n_fail++; $display("FAIL lb_retire: got %b/%h/%0d exp 1/%h/%0d", retire, pc, instret, m_pc, m_instret); end
      @(negedge clk);
      n_checks++; if (rd_we !== 1'b0 || retire !== 1'b0) begin
         n_fail++; $display("FAIL lb_pulse: got rd_we=%b retire=%b exp 0/0", rd_we, retire); end
      clear_dp();
   endtask

   task automatic test_store_half();
      bit seen; logic [31:0] fa;
      fetch(0, 32'h0011_9123, seen, fa);
      n_checks++; if (!seen || fa !== m_pc) begin n_fail++; $display("FAIL sh_fetch: got seen=%b addr %h exp 1/%h", seen, fa, m_pc); end
      dp_store = 1; dp_size = 1; dp_addr = 32'h202; dp_wdata = 32'h1234; dp_pc_next = 32'h40;
      @(negedge clk);
      n_checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h200 || bus.mem_be !== 4'b1100) begin
         n_fail++; $display("FAIL sh_bus: got we=%b addr=%h be=%b exp 1/200/1100", bus.mem_we, bus.mem_addr, bus.mem_be); end
      n_checks++; if (bus.mem_wdata !== 32'h1234_0000) begin n_fail++; $display("FAIL sh_wdata: got %h exp 12340000", bus.mem_wdata); end
      repeat (2) @(negedge clk);
      n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_wdata !== 32'h1234_0000 || bus.mem_be !== 4'b1100) begin
         n_fail++; $display("FAIL sh_hold: got req=%b wdata=%h be=%b exp 1/12340000/1100", bus.mem_req, bus.mem_wdata, bus.mem_be); end
      bus.mem_ready = 1'b1;
      @(negedge clk);
      bus.mem_ready = 1'b0;
      m_pc = 32'h40; m_instret++;
      n_checks++; if (rd_we !== 1'b0 || retire !== 1'b1 || pc !== m_pc || instret !== m_instret) begin
         n_fail++; $display("FAIL sh_retire: got rd_we=%b retire=%b pc=%h instret=%0d exp 0/1/%h/%0d", rd_we, retire, pc, instret, m_pc, m_instret); end
      clear_dp();
   endtask

   task automatic test_misaligned();
      bit seen; logic [31:0] fa;
      fetch(0, 32'h1010_2083, seen, fa);
      n_checks++; if (!seen || fa !== m_pc) begin n_fail++; $display("FAIL lw_fetch: got seen=%b addr %h exp 1/%h", seen, fa, m_pc); end
      dp_load = 1; dp_size = 2; dp_addr = 32'h101; dp_pc_next = m_pc + 4; csr_mtvec = 32'h400;
      @(negedge clk);
      n_checks++; if (trap_we !== 1'b1 || trap_cause !== 32'd4 || trap_epc !== m_pc) begin
         n_fail++; $display("FAIL lw_trap: got we=%b cause=%0d epc=%h exp 1/4/%h", trap_we, trap_cause, trap_epc, m_pc); end
      n_checks++; if (bus.mem_req !== 1'b0 || retire !== 1'b0 || rd_we !== 1'b0) begin
         n_fail++; $display("FAIL lw_noaccess: got req=%b retire=%b rd_we=%b exp 0/0/0", bus.mem_req, retire, rd_we); end
      @(negedge clk);
      m_pc = 32'h400;
      n_checks++; if (pc !== m_pc || instret !== m_instret || trap_we !== 1'b0) begin
         n_fail++; $display("FAIL lw_vector: got pc=%h instret=%0d trap_we=%b exp %h/%0d/0", pc, instret, trap_we, m_pc, m_instret); end
      n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== m_pc) begin
         n_fail++; $display("FAIL lw_refetch: got req=%b addr=%h exp 1/%h", bus.mem_req, bus.mem_addr, m_pc); end
      clear_dp();
   endtask

   task automatic test_fetch_timeout();
      bit seen; logic [31:0] fa, w;
      int unsigned n = 0;
      csr_mtvec = 32'h800;
      while (bus.mem_req === 1'b1 && n < 40) begin n++; @(negedge clk); end
      n_checks++; if (n !== TMO) begin n_fail++; $display("FAIL tmo_req_cycles: got %0d exp %0d", n, TMO); end
      n_checks++; if (trap_we !== 1'b1 || trap_cause !== 32'd1 || trap_epc !== m_pc) begin
         n_fail++; $display("FAIL tmo_trap: got we=%b cause=%0d epc=%h exp 1/1/%h", trap_we, trap_cause, trap_epc, m_pc); end
      @(negedge clk);
      m_pc = 32'h800;
      n_checks++; if (pc !== m_pc || instret !== m_instret) begin
         n_fail++; $display("FAIL tmo_vector: got pc=%h instret=%0d exp %h/%0d", pc, instret, m_pc, m_instret); end
      // Data arrives in the last allowed wait cycle: must complete normally
      w = $urandom;
      fetch(TMO - 1, w, seen, fa);
      n_checks++; if (dec_valid !== 1'b1 || trap_we !== 1'b0 || ir !== w) begin
         n_fail++; $display("FAIL tmo_edge: got dec_valid=%b trap_we=%b ir=%h exp 1/0/%h", dec_valid, trap_we, ir, w); end
      dp_pc_next = 32'h804;
      @(negedge clk);
      m_pc = 32'h804; m_instret++;
      n_checks++; if (retire !== 1'b1 || pc !== m_pc || instret !== m_instret) begin
         n_fail++; $display("FAIL tmo_edge_retire: got %b/%h/%0d exp 1/%h/%0d", retire, pc, instret, m_pc, m_instret); end
      clear_dp();
   endtask

   task automatic test_random();
      bit ill, ec, mr, ld, st, un, seen;
      int unsigned sz, fw, mw, cause, r;
      logic [31:0] ad, wd, pn, tv, ep, word, rdata, fa, exp_addr;
      for (int i = 0; i < 80; i++) begin
         ill = ($urandom_range(0, 9) == 0);
         ec  = ($urandom_range(0, 9) == 0);
         mr  = ($urandom_range(0, 7) == 0);
         r   = $urandom_range(0, 2);
         ld  = (r == 1); st = (r == 2);
         un  = $urandom_range(0, 1);
         sz  = $urandom_range(0, 2);
         ad  = $urandom;
         if ($urandom_range(0, 3) != 0) ad = ad - (ad % (32'd1 << sz));
         wd = $urandom; pn = $urandom; tv = $urandom & ~32'h3; ep = $urandom; word = $urandom;
         fw = ($urandom_range(0, 7) == 0) ? TMO - 1 : $urandom_range(0, 2);
         r  = $urandom_range(0, 9);
         mw = (r == 0) ? TMO : (r == 1) ? TMO - 1 : $urandom_range(0, 2);
         exp_addr = ad - (ad % 4);

         fetch(fw, word, seen, fa);
         n_checks++; if (!seen || fa !== m_pc) begin n_fail++; $display("FAIL rnd_fetch[%0d]: got seen=%b addr=%h exp 1/%h", i, seen, fa, m_pc); end
         n_checks++; if (dec_valid !== 1'b1 || ir !== word) begin
            n_fail++; $display("FAIL rnd_decode[%0d]: got dec_valid=%b ir=%h exp 1/%h", i, dec_valid, ir, word); end
         dp_illegal = ill; dp_ecall = ec; dp_mret = mr; dp_load = ld; dp_store = st; dp_unsigned = un;
         dp_size = 2'(sz); dp_addr = ad; dp_wdata = wd; dp_pc_next = pn; csr_mtvec = tv; csr_mepc = ep;
         @(negedge clk);
         cause = ref_cause(ill, ec, ld, st, sz, ad);
         if (cause == 0 && !mr && (ld || st) && mw >= TMO) cause = 0;
         if (cause != 0) begin
            n_checks++; if (trap_we !== 1'b1 || trap_cause !== cause || trap_epc !== m_pc) begin
               n_fail++; $display("FAIL rnd_trap[%0d]: got we=%b cause=%0d epc=%h exp 1/%0d/%h", i, trap_we, trap_cause, trap_epc, cause, m_pc); end
            n_checks++; if (retire !== 1'b0 || rd_we !== 1'b0 || bus.mem_req !== 1'b0) begin
               n_fail++; $display("FAIL rnd_trap_quiet[%0d]: got retire=%b rd_we=%b req=%b exp 0/0/0", i, retire, rd_we, bus.mem_req); end
            @(negedge clk);
            m_pc = tv;
            n_checks++; if (pc !== m_pc || instret !== m_instret) begin
               n_fail++; $display("FAIL rnd_trap_pc[%0d]: got %h/%0d exp %h/%0d", i, pc, instret, m_pc, m_instret); end
         end else if (mr || !(ld || st)) begin
            m_pc = mr ? ep : pn; m_instret++;
            n_checks++; if (retire !== 1'b1 || trap_we !== 1'b0 || rd_we !== 1'b0 || pc !== m_pc || instret !== m_instret) begin
               n_fail++; $display("FAIL rnd_alu[%0d]: got retire=%b trap_we=%b rd_we=%b pc=%h instret=%0d exp 1/0/0/%h/%0d",
                                  i, retire, trap_we, rd_we, pc, instret, m_pc, m_instret); end
         end else begin
            n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== st || bus.mem_addr !== exp_addr || bus.mem_be !== ref_be(sz, ad)) begin
               n_fail++; $display("FAIL rnd_bus[%0d]: got req=%b we=%b addr=%h be=%b exp 1/%b/%h/%b",
                                  i, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, st, exp_addr, ref_be(sz, ad)); end
            if (st) begin
               n_checks++; if (bus.mem_wdata !== wd * (32'd1 << (8 * (ad % 4)))) begin
                  n_fail++; $display("FAIL rnd_wdata[%0d]: got %h exp %h", i, bus.mem_wdata, wd * (32'd1 << (8 * (ad % 4)))); end
            end
            repeat (mw) @(negedge clk);
            if (mw >= TMO) begin
               n_checks++; if (trap_we !== 1'b1 || trap_cause !== (ld ? 32'd5 : 32'd7) || trap_epc !== m_pc || bus.mem_req !== 1'b0) begin
                  n_fail++; $display("FAIL rnd_mem_tmo[%0d]: got we=%b cause=%0d epc=%h req=%b exp 1/%0d/%h/0",
                                     i, trap_we, trap_cause, trap_epc, bus.mem_req, ld ? 5 : 7, m_pc); end
               @(negedge clk);
               m_pc = tv;
               n_checks++; if (pc !== m_pc || instret !== m_instret || retire !== 1'b0) begin
                  n_fail++; $display("FAIL rnd_mem_tmo_pc[%0d]: got %h/%0d/%b exp %h/%0d/0", i, pc, instret, retire, m_pc, m_instret); end
            end else begin
               n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== exp_addr) begin
                  n_fail++; $display("FAIL rnd_hold[%0d]: got req=%b addr=%h exp 1/%h", i, bus.mem_req, bus.mem_addr, exp_addr); end
               rdata = $urandom;
               bus.mem_ready = 1'b1; bus.mem_rdata = rdata;
               @(negedge clk);
               bus.mem_ready = 1'b0;
               m_pc = pn; m_instret++;
               n_checks++; if (retire !== 1'b1 || rd_we !== ld || pc !== m_pc || instret !== m_instret) begin
                  n_fail++; $display("FAIL rnd_mem_done[%0d]: got retire=%b rd_we=%b pc=%h instret=%0d exp 1/%b/%h/%0d",
                                     i, retire, rd_we, pc, instret, ld, m_pc, m_instret); end
               if (ld) begin
                  n_checks++; if (rd_wd !== ref_load(rdata, sz, ad, un)) begin
                     n_fail++; $display("FAIL rnd_rd_wd[%0d]: got %h exp %h", i, rd_wd, ref_load(rdata, sz, ad, un)); end
               end
            end
         end
         clear_dp();
      end
   endtask

   task automatic test_reset_mid_mem();
      bit seen; logic [31:0] fa;
      fetch(0, 32'h0003_2003, seen, fa);
      dp_load = 1; dp_size = 2; dp_addr = 32'h300; dp_pc_next = m_pc + 4;
      @(negedge clk);
      n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL rstm_in_mem: got req=%b exp 1", bus.mem_req); end
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (bus.mem_req !== 1'b0 || pc !== RST_PC || instret !== 64'h0 || ir !== 32'h0) begin
         n_fail++; $display("FAIL rstm_async: got req=%b pc=%h instret=%0d ir=%h exp 0/%h/0/0", bus.mem_req, pc, instret, ir, RST_PC); end
      @(negedge clk);
      rst_n = 1'b1;
      clear_dp();
      m_pc = RST_PC; m_instret = 0;
      @(negedge clk);
      fetch(0, 32'h0000_0013, seen, fa);
      n_checks++; if (!seen || fa !== RST_PC) begin n_fail++; $display("FAIL rstm_refetch: got seen=%b addr=%h exp 1/%h", seen, fa, RST_PC); end
      dp_pc_next = RST_PC + 4;
      @(negedge clk);
      n_checks++; if (retire !== 1'b1 || pc !== RST_PC + 4 || instret !== 64'd1) begin
         n_fail++; $display("FAIL rstm_retire: got %b/%h/%0d exp 1/%h/1", retire, pc, instret, RST_PC + 4); end
      clear_dp();
   endtask

   initial begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      csr_mtvec = '0;
      csr_mepc  = '0;
      clear_dp();
      test_reset();
      test_alu_latency();
      test_load_byte();
      test_store_half();
      test_misaligned();
      test_fetch_timeout();
      test_random();
      test_reset_mid_mem();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC loaded on reset.
REQ-002 SHALL have parameter TIMEOUT, default 16: maximum number of wait cycles on the memory bus before an access fault; range 1..255.
REQ-003 SHALL have parameter CNT_W, default 64: width of the retired-instruction counter.
REQ-004 SHALL provide ports as follows; single clock domain; reset is asynchronous, active-low:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mem_req  out  1  bus request, held until mem_ready
- mem_we  out  1  write strobe
- mem_addr  out  32  word-aligned byte address
- mem_be  out  4  byte enables
- mem_wdata  out  32  write data, lane-shifted
- mem_ready  in  1  access complete this cycle
- mem_rdata  in  32  read data
- pc  out  32  current instruction address
- ir  out  32  latched instruction
- dec_valid  out  1  one-cycle strobe: ir is stable and the datapath decode is sampled
- dp_illegal, dp_ecall, dp_mret, dp_load, dp_store, dp_unsigned  in  1 each  decode flags from the datapath
- dp_size  in  2  access size: 0=byte, 1=half, 2=word
- dp_addr  in  32  effective address
- dp_wdata  in  32  unshifted store data
- dp_pc_next  in  32  next PC for non-trap instructions
- csr_mtvec, csr_mepc  in  32 each  trap vector and return address
- rd_we  out  1  register-file write strobe
- rd_wd  out  32  extended load data
- trap_we  out  1  one-cycle strobe: write mcause and mepc
- trap_cause  out  32  mcause value
- trap_epc  out  32  mepc value
- retire  out  1  one-cycle instruction-retired pulse
- instret  out  CNT_W  retired-instruction count

Function
REQ-005 SHALL implement the FSM states FETCH, DECODE, MEM, TRAP.
REQ-006 FETCH: SHALL assert mem_req with mem_we=0, mem_addr=pc, mem_be=4'hF; on mem_ready SHALL latch ir<=mem_rdata and go to DECODE.
REQ-007 DECODE: SHALL assert dec_valid for exactly one cycle, then select the first matching case in this priority order:
- dp_illegal -> TRAP, cause 2
- dp_ecall -> TRAP, cause 11
- load/store misaligned (half with addr[0]=1, word with addr[1:0]!=0) -> TRAP, cause 4 for load / 6 for store
- dp_mret -> pc<=csr_mepc, retire, then FETCH
- dp_load or dp_store -> MEM
- otherwise -> pc<=dp_pc_next, retire, then FETCH
REQ-008 MEM: mem_addr SHALL be {dp_addr[31:2],2'b00}.
- mem_be: byte = 1<<addr[1:0]; half = 2'b11<<addr[1:0]; word = 4'hF.
- mem_wdata SHALL be dp_wdata shifted left by 8*addr[1:0].
- Write SHALL be a single bus access with no read-modify-write.
REQ-009 On a load completion in MEM: rd_wd SHALL be the selected lane, sign- or zero-extended per dp_unsigned, with rd_we=1 for one cycle; then pc<=dp_pc_next, retire, FETCH.
REQ-010 On a store completion in MEM: rd_we SHALL stay 0; then pc<=dp_pc_next, retire, FETCH.
REQ-011 A wait counter SHALL count the consecutive cycles with mem_req=1 and mem_ready=0; on reaching TIMEOUT SHALL drop mem_req and go to TRAP.
- Cause 1 when in FETCH; 5 for a load; 7 for a store.
- A mem_ready arriving in the same cycle the count is reached SHALL win: the access completes and no trap is taken.
REQ-012 TRAP: SHALL assert trap_we for one cycle with trap_cause and trap_epc=pc; pc<=csr_mtvec; no retire; go to FETCH.
REQ-013 Trapping instructions SHALL NOT assert rd_we or retire.
REQ-014 instret SHALL increment by one on each retire pulse and wrap modulo 2^CNT_W.
REQ-015 Fetch-to-retire latency with zero wait states SHALL be 2 cycles for ALU/branch/mret and 3 cycles for load/store; each wait cycle adds one.
REQ-016 mem_req SHALL stay asserted, with all bus outputs stable, until mem_ready or timeout.
REQ-017 An unknown opcode SHALL never stop simulation; it traps via dp_illegal.

Reset
REQ-018 rst_n=0 SHALL immediately (asynchronously) force the following, even in the middle of a bus access:
- FSM state = FETCH
- pc = RESET_PC; ir = 0
- wait counter = 0; instret = 0
- all strobes (mem_req, mem_we, rd_we, trap_we, retire, dec_valid) = 0
- mem_addr, mem_be, mem_wdata, rd_wd, trap_cause, trap_epc = 0
REQ-019 mem_req SHALL rise in the first cycle after rst_n deasserts.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Zero-wait ALU instruction with dp_pc_next=4 -> retire at cycle 2, pc=4, instret=1.
- lb at dp_addr=0x103, mem_rdata=0x80xx_xxxx, dp_unsigned=0 -> mem_be=4'b1000, rd_wd=0xFFFF_FF80.
- sh at dp_addr=0x202, dp_wdata=0x1234 -> mem_be=4'b1100, mem_wdata=0x1234_0000.
- lw at dp_addr=0x101 -> no bus access, trap_cause=4, trap_epc=pc, pc=csr_mtvec, instret unchanged.
- Fetch with mem_ready held low, TIMEOUT=16 -> mem_req drops after 16 cycles, trap_cause=1; a second run with mem_ready at wait cycle 16 -> normal completion.
- rst_n pulsed low during a MEM wait -> mem_req=0 immediately, pc=RESET_PC, instret=0, next fetch from RESET_PC.
